// File: rtl/tt_spine_ctrl.sv
// Spine-side controller: design-select address, break-before-make ena sequencing, user IO gating.
// Optional build macro TT_SPINE_CTRL_SYNC_EN adds 2-flop synchronizers on the pad strobes and ena_req.
module tt_spine_ctrl #(
  parameter int N_IO       = 8,
  parameter int N_O        = 8,
  parameter int N_I        = 10,
  parameter int SETTLE_CYC = 4,
  parameter int S_OW       = N_O + 2*N_IO + 2,
  parameter int S_IW       = N_I + N_IO + 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sel_inc,
  input  logic              sel_rst_n,
  input  logic              ena_req,
  input  logic [N_I-1:0]    ui_in,
  input  logic [N_IO-1:0]   uio_in,
  output logic [N_O-1:0]    uo_out,
  output logic [N_IO-1:0]   uio_out,
  output logic [N_IO-1:0]   uio_oe,
  output logic [S_IW-1:0]   spine_iw,
  input  logic [S_OW-1:0]   spine_ow,
  output logic [9:0]        cur_sel,
  output logic              active
);

  localparam int USR_IW = N_I + N_IO;
  localparam int USR_OW = N_O + 2*N_IO;
  localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYC);

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_DROP   = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  // pad_s = {ena_req, sel_rst_n, sel_inc} after optional synchronization
  logic [2:0] pad_s;

`ifdef TT_SPINE_CTRL_SYNC_EN
  logic [2:0] sync1_r;
  logic [2:0] sync2_r;

  // Two-flop synchronizer for the asynchronous pad controls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 3'b010;
      sync2_r <= 3'b010;
    end else begin
      sync1_r <= {ena_req, sel_rst_n, sel_inc};
      sync2_r <= sync1_r;
    end
  end

  assign pad_s = sync2_r;
`else
  assign pad_s = {ena_req, sel_rst_n, sel_inc};
`endif

  logic [1:0] cond_r;
  logic [1:0] prev_r;
  logic       inc_s;
  logic       clr_s;
  logic       event_s;
  logic       ena_cond_s;

  // Edge-detect stage for the two strobes: {sel_rst_n, sel_inc}
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cond_r <= 2'b10;
      prev_r <= 2'b10;
    end else begin
      cond_r <= pad_s[1:0];
      prev_r <= cond_r;
    end
  end

  assign clr_s      = prev_r[1] & ~cond_r[1];
  assign inc_s      = cond_r[0] & ~prev_r[0] & ~clr_s;
  assign event_s    = clr_s | inc_s;
  assign ena_cond_s = pad_s[2];

  state_t     state_r;
  state_t     state_next_s;
  logic [9:0] sel_r;
  logic [9:0] sel_next_s;
  logic [7:0] cnt_r;
  logic [7:0] cnt_next_s;
  logic       pend_clr_r;
  logic       pend_clr_next_s;
  logic       ena_r;
  logic       ena_next_s;
  logic       active_r;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_SETTLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state, address and settle-count logic
  always_comb begin
    state_next_s    = state_r;
    sel_next_s      = sel_r;
    cnt_next_s      = cnt_r;
    pend_clr_next_s = pend_clr_r;
    case (state_r)
      ST_ACTIVE: begin
        if (event_s) begin
          pend_clr_next_s = clr_s;
          state_next_s    = ST_DROP;
        end else begin
          state_next_s    = ST_ACTIVE;
        end
      end
      ST_DROP: begin
        if (pend_clr_r) begin
          sel_next_s = 10'd0;
        end else begin
          sel_next_s = sel_r + 10'd1;
        end
        cnt_next_s   = SETTLE_LD;
        state_next_s = ST_SETTLE;
      end
      ST_SETTLE: begin
        // Events here retarget immediately; ena is already low
        if (event_s) begin
          if (clr_s) begin
            sel_next_s = 10'd0;
          end else begin
            sel_next_s = sel_r + 10'd1;
          end
          cnt_next_s = SETTLE_LD;
        end else if (cnt_r == 8'd1) begin
          state_next_s = ST_ACTIVE;
        end else begin
          cnt_next_s = cnt_r - 8'd1;
        end
      end
      default: begin
        state_next_s = ST_SETTLE;
        cnt_next_s   = SETTLE_LD;
      end
    endcase
  end

  // ena only follows the request in cycles that will be ACTIVE
  always_comb begin
    ena_next_s = 1'b0;
    if (state_next_s == ST_ACTIVE) begin
      ena_next_s = ena_cond_s;
    end else begin
      ena_next_s = 1'b0;
    end
  end

  // Datapath registers and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_r      <= 10'd0;
      cnt_r      <= SETTLE_LD;
      pend_clr_r <= 1'b0;
      ena_r      <= 1'b0;
      active_r   <= 1'b0;
    end else begin
      sel_r      <= sel_next_s;
      cnt_r      <= cnt_next_s;
      pend_clr_r <= pend_clr_next_s;
      ena_r      <= ena_next_s;
      active_r   <= (state_next_s == ST_ACTIVE);
    end
  end

  logic [USR_IW-1:0] usr_in_s;
  logic [USR_OW-1:0] usr_out_s;
  logic              ow_guard_unused_s;

  assign usr_in_s  = active_r ? {uio_in, ui_in} : {USR_IW{1'b0}};
  assign usr_out_s = active_r ? spine_ow[S_OW-2:1] : {USR_OW{1'b0}};
  assign ow_guard_unused_s = spine_ow[S_OW-1] ^ spine_ow[0];

  assign spine_iw = {1'b0, usr_in_s, sel_r, ena_r, 1'b0};
  assign uo_out   = usr_out_s[N_O-1:0];
  assign uio_out  = usr_out_s[N_O+N_IO-1:N_O];
  assign uio_oe   = usr_out_s[USR_OW-1:N_O+N_IO];
  assign cur_sel  = sel_r;
  assign active   = active_r;

endmodule

// File: tb/tb_tt_spine_ctrl.sv
// Self-checking bench for tt_spine_ctrl (default build): directed corner cases, a gating vector
// table and randomized pad activity, all checked against a timestamp-based reference model.
module tb_tt_spine_ctrl;
  localparam int N_IO = 8;
  localparam int N_O  = 8;
  localparam int N_I  = 10;
  localparam int SC   = 4;
  localparam int S_OW = N_O + 2*N_IO + 2;
  localparam int S_IW = N_I + N_IO + 13;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            sel_inc = 1'b0;
  logic            sel_rst_n = 1'b1;
  logic            ena_req = 1'b0;
  logic [N_I-1:0]  ui_in = '0;
  logic [N_IO-1:0] uio_in = '0;
  logic [S_OW-1:0] spine_ow = '0;
  logic [N_O-1:0]  uo_out;
  logic [N_IO-1:0] uio_out;
  logic [N_IO-1:0] uio_oe;
  logic [S_IW-1:0] spine_iw;
  logic [9:0]      cur_sel;
  logic            active;

  tt_spine_ctrl #(.N_IO(N_IO), .N_O(N_O), .N_I(N_I), .SETTLE_CYC(SC)) dut (
    .clk(clk), .rst_n(rst_n), .sel_inc(sel_inc), .sel_rst_n(sel_rst_n), .ena_req(ena_req),
    .ui_in(ui_in), .uio_in(uio_in), .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe),
    .spine_iw(spine_iw), .spine_ow(spine_ow), .cur_sel(cur_sel), .active(active)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the selection is live once SC cycles have passed since the last
  // address change, except in the single drop cycle that precedes an ACTIVE-time change.
  int         cyc;
  int         settle_start;
  int         drop_at;
  int         pend_at;
  logic       pend_clr;
  logic [9:0] sel_m;
  logic       c1_inc, c2_inc, c1_rst, c2_rst;
  logic       ena_prev;

  function automatic logic active_m(input int c);
    return (c != drop_at) && ((c - settle_start) >= SC);
  endfunction

  task automatic model_reset();
    cyc = 0; settle_start = 0; drop_at = -100; pend_at = -100; pend_clr = 1'b0;
    sel_m = 10'd0; c1_inc = 1'b0; c2_inc = 1'b0; c1_rst = 1'b1; c2_rst = 1'b1;
    ena_prev = 1'b0;
  endtask

  // Advance the model across one rising edge, using the pad values seen at that edge
  task automatic model_edge();
    logic ev_inc, ev_clr;
    ev_clr = c2_rst & ~c1_rst;
    ev_inc = c1_inc & ~c2_inc;
    if (ev_inc || ev_clr) begin
      if (active_m(cyc)) begin
        drop_at = cyc + 1; pend_at = cyc + 2; pend_clr = ev_clr; settle_start = cyc + 2;
      end else if (cyc != drop_at) begin
        sel_m = ev_clr ? 10'd0 : sel_m + 10'd1;
        settle_start = cyc + 1;
      end
    end
    if (cyc + 1 == pend_at) sel_m = pend_clr ? 10'd0 : sel_m + 10'd1;
    ena_prev = ena_req;
    c2_inc = c1_inc; c1_inc = sel_inc;
    c2_rst = c1_rst; c1_rst = sel_rst_n;
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, got, exp);
    end
  endtask

  task automatic check_all();
    logic a;
    logic [17:0] eu;
    logic [23:0] eo;
    a  = active_m(cyc);
    eu = a ? {uio_in, ui_in} : 18'd0;
    eo = a ? spine_ow[S_OW-2:1] : 24'd0;
    chk("active", 32'(active), 32'(a));
    chk("cur_sel", 32'(cur_sel), 32'(sel_m));
    chk("spine_iw", 32'(spine_iw), 32'({1'b0, eu, sel_m, (a ? ena_prev : 1'b0), 1'b0}));
    chk("usr_out", 32'({uio_oe, uio_out, uo_out}), 32'(eo));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic pulse_inc();
    sel_inc = 1'b1; step();
    sel_inc = 1'b0; step();
  endtask

  task automatic wait_active(input int budget);
    int k;
    k = 0;
    while (!active && k < budget) begin
      step();
      k++;
    end
    chk("wait_active", 32'(active), 32'd1);
  endtask

  typedef struct {
    logic [9:0]      ui;
    logic [7:0]      uio;
    logic [S_OW-1:0] ow;
    logic [17:0]     exp_usr;
    logic [7:0]      exp_uo;
    logic [7:0]      exp_uio;
    logic [7:0]      exp_oe;
  } gate_vec_t;

  gate_vec_t gv[4];

  initial begin
    gv[0] = '{10'h155, 8'hA5, {1'b1, 8'h12, 8'h34, 8'h56, 1'b1}, 18'h29555, 8'h56, 8'h34, 8'h12};
    gv[1] = '{10'h000, 8'h00, {1'b0, 8'hFF, 8'h00, 8'hFF, 1'b0}, 18'h00000, 8'hFF, 8'h00, 8'hFF};
    gv[2] = '{10'h3FF, 8'h00, {1'b1, 8'h00, 8'hC3, 8'h00, 1'b0}, 18'h003FF, 8'h00, 8'hC3, 8'h00};
    gv[3] = '{10'h001, 8'h80, {1'b0, 8'h81, 8'h7E, 8'h01, 1'b1}, 18'h20001, 8'h01, 8'h7E, 8'h81};

    model_reset();
    ena_req = 1'b1;
    ui_in = 10'h3FF; uio_in = 8'hFF; spine_ow = {S_OW{1'b1}};
    #12;
    chk("rst_sel", 32'(cur_sel), 32'd0);
    chk("rst_iw", 32'(spine_iw), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_out", 32'({uio_oe, uio_out, uo_out}), 32'd0);

    // Reset release: four settle cycles at sel 0, then live
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    check_all();
    for (int i = 0; i < SC; i++) begin
      chk("rel_sel", 32'(cur_sel), 32'd0);
      chk("rel_ena", 32'(spine_iw[1]), 32'd0);
      chk("rel_uo", 32'(uo_out), 32'd0);
      if (i < SC - 1) step();
    end
    step();
    chk("rel_active", 32'(active), 32'd1);
    chk("rel_ena_up", 32'(spine_iw[1]), 32'd1);
    chk("rel_uo_up", 32'(uo_out), 32'hFF);

    // Table of gating vectors applied while live
    for (int i = 0; i < 4; i++) begin
      ui_in = gv[i].ui; uio_in = gv[i].uio; spine_ow = gv[i].ow;
      #1;
      chk("gate_usr", 32'(spine_iw[29:12]), 32'(gv[i].exp_usr));
      chk("gate_uo", 32'(uo_out), 32'(gv[i].exp_uo));
      chk("gate_uio", 32'(uio_out), 32'(gv[i].exp_uio));
      chk("gate_oe", 32'(uio_oe), 32'(gv[i].exp_oe));
    end

    // Reach sel 5, then one inc: ena drops a cycle before sel moves, returns 4 clk later
    for (int i = 0; i < 5; i++) pulse_inc();
    wait_active(20);
    chk("sel5", 32'(cur_sel), 32'd5);
    sel_inc = 1'b1; step();
    chk("inc_t_ena", 32'(spine_iw[1]), 32'd1);
    sel_inc = 1'b0; step();
    chk("drop_ena", 32'(spine_iw[1]), 32'd0);
    chk("drop_sel", 32'(cur_sel), 32'd5);
    step();
    chk("settle_sel6", 32'(cur_sel), 32'd6);
    for (int i = 0; i < SC - 1; i++) begin
      step();
      chk("settle_ena_low", 32'(spine_iw[1]), 32'd0);
    end
    step();
    chk("ena_back", 32'(spine_iw[1]), 32'd1);

    // Clear, then three incs 2 clk apart with counter reload on each
    sel_rst_n = 1'b0; step();
    sel_rst_n = 1'b1; step();
    wait_active(20);
    chk("clr_sel0", 32'(cur_sel), 32'd0);
    for (int i = 0; i < 3; i++) pulse_inc();
    chk("tri_sel3", 32'(cur_sel), 32'd3);
    for (int i = 0; i < SC - 1; i++) begin
      step();
      chk("tri_not_active", 32'(active), 32'd0);
    end
    step();
    chk("tri_active", 32'(active), 32'd1);

    // Wrap from 1023 to 0
    for (int i = 0; i < 1020; i++) pulse_inc();
    wait_active(20);
    chk("sel1023", 32'(cur_sel), 32'd1023);
    pulse_inc();
    wait_active(20);
    chk("wrap0", 32'(cur_sel), 32'd0);

    // Simultaneous clr and inc at sel 7: clear wins
    for (int i = 0; i < 7; i++) pulse_inc();
    wait_active(20);
    chk("sel7", 32'(cur_sel), 32'd7);
    sel_inc = 1'b1; sel_rst_n = 1'b0; step();
    sel_inc = 1'b0; sel_rst_n = 1'b1; step();
    wait_active(20);
    chk("both_sel0", 32'(cur_sel), 32'd0);

    // Gating while settling with all-ones data
    pulse_inc();
    ui_in = 10'h3FF; uio_in = 8'hFF; spine_ow = {S_OW{1'b1}};
    step();
    chk("settle_usr0", 32'(spine_iw[29:12]), 32'd0);
    chk("settle_out0", 32'({uio_oe, uio_out, uo_out}), 32'd0);
    wait_active(20);
    chk("live_usr", 32'(spine_iw[29:12]), 32'h3FFFF);
    chk("live_out", 32'({uio_oe, uio_out, uo_out}), 32'hFFFFFF);

    // Reset mid-settle at sel 42
    sel_rst_n = 1'b0; step();
    sel_rst_n = 1'b1; step();
    wait_active(20);
    for (int i = 0; i < 42; i++) pulse_inc();
    chk("sel42", 32'(cur_sel), 32'd42);
    chk("sel42_settle", 32'(active), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sel", 32'(cur_sel), 32'd0);
    chk("mid_rst_iw", 32'(spine_iw), 32'd0);
    chk("mid_rst_out", 32'({uio_oe, uio_out, uo_out}), 32'd0);
    chk("mid_rst_active", 32'(active), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    check_all();
    for (int i = 0; i < SC - 1; i++) step();
    chk("post_rst_settling", 32'(active), 32'd0);
    step();
    chk("post_rst_active", 32'(active), 32'd1);
    chk("post_rst_sel", 32'(cur_sel), 32'd0);

    // Randomized pad activity; strobes change only every other cycle
    for (int i = 0; i < 800; i++) begin
      if (i % 2 == 0) begin
        if ($urandom_range(0, 3) == 0) sel_inc = ~sel_inc;
        if ($urandom_range(0, 7) == 0) sel_rst_n = ~sel_rst_n;
      end
      if ($urandom_range(0, 5) == 0) ena_req = ~ena_req;
      ui_in = 10'($urandom); uio_in = 8'($urandom); spine_ow = S_OW'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
